// File: rtl/rf_pkg.sv
// Shared constants and packed-port slicing helpers for the multiport register file.
package rf_pkg;

    localparam int XLEN_D   = 32;
    localparam int NREGS_D  = 32;
    localparam int REG_ZERO = 0;

    // Bit offset of port `port` inside a packed address bus of `aw`-bit fields.
    function automatic int slice_addr(input int port, input int aw);
        return port * aw;
    endfunction

    // Bit offset of port `port` inside a packed data bus of `xlen`-bit fields.
    function automatic int slice_data(input int port, input int xlen);
        return port * xlen;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets a register busy, writeback clears it; issue wins.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    parameter int AW    = $clog2(NREGS),
    parameter int NWR   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREGS-1:0]  busy_vec
);

    // Bit 0 is the zero register and can never become busy.
    localparam logic [NREGS-1:0] KEEP_MASK = {{(NREGS-1){1'b1}}, 1'b0};

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en) begin
            set_vec[iss_addr] = 1'b1;
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                clr_vec[wr_addr[slice_addr(j, AW) +: AW]] = 1'b1;
            end
        end
    end

    // A same-cycle issue overrides the clear from an older producer's writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= (set_vec | (busy_q & ~clr_vec)) & KEEP_MASK;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file with busy scoreboard; r0 reads as zero and never goes busy.
// Optional write-through read bypass enabled by defining RF_BYPASS_EN.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;

    // Ports are walked in ascending order so the highest-indexed write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[slice_addr(j, AW) +: AW] != AW'(REG_ZERO))) begin
                    regs[wr_addr[slice_addr(j, AW) +: AW]] <= wr_data[slice_data(j, XLEN) +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_q)
    );

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbsy;

        assign ra = rd_addr[slice_addr(k, AW) +: AW];

        always_comb begin
            rdat = '0;
            rbsy = 1'b0;
            if (!reset && (ra != AW'(REG_ZERO))) begin
                rdat = regs[ra];
                rbsy = busy_q[ra];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[slice_addr(j, AW) +: AW] == ra)) begin
                        rdat = wr_data[slice_data(j, XLEN) +: XLEN];
                        rbsy = iss_en && (iss_addr == ra);
                    end
                end
`endif
            end
        end

        assign rd_data[slice_data(k, XLEN) +: XLEN] = rdat;
        assign rd_busy[k] = rbsy;
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb: array-level reference model plus directed literal checks.
module tb_rf_multiport_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREGS-1:0]    busy_vec;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    rf_multiport_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                logic hit;
                hit = 1'b0;
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == r) begin
                        m_regs[r] = wr_data[j*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
                if (iss_en && int'(iss_addr) == r) m_busy[r] = 1'b1;
                else if (hit)                     m_busy[r] = 1'b0;
            end
        end
    end

    // Compare process: every falling edge, check all outputs against the model.
    always @(negedge clk) begin
        logic [XLEN-1:0]  ed;
        logic             eb;
        logic [NREGS-1:0] ev;
        int               a;
        for (int k = 0; k < NRD; k++) begin
            a  = int'(rd_addr[k*AW +: AW]);
            ed = '0;
            eb = 1'b0;
            if (!reset && a != 0) begin
                ed = m_regs[a];
                eb = m_busy[a];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                        ed = wr_data[j*XLEN +: XLEN];
                        eb = iss_en && int'(iss_addr) == a;
                    end
                end
`endif
            end
            chk($sformatf("model rd_data[%0d]", k), 64'(rd_data[k*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("model rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(eb));
        end
        for (int r = 0; r < NREGS; r++) ev[r] = m_busy[r];
        chk("model busy_vec", 64'(busy_vec), 64'(ev));
    end

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[j]              = 1'b1;
        wr_addr[j*AW +: AW]   = a;
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        set_rd(5'd5, 5'd3);
        step();
        step();
        @(negedge clk);
        chk("reset held rd_data", 64'(rd_data), 64'h0);
        chk("reset held busy_vec", 64'(busy_vec), 64'h0);
        step();

        // Reset clears state and discards a same-cycle write
        reset = 1'b0;
        set_wr(0, 5'd5, 32'hDEADBEEF);
        issue(5'd5);
        step();
        idle();
        @(negedge clk);
        chk("r5 written", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("r5 busy", 64'(busy_vec[5]), 64'h1);
        reset = 1'b1;
        set_wr(1, 5'd3, 32'h0BAD0BAD);
        @(negedge clk);
        chk("reset rd_data zero", 64'(rd_data), 64'h0);
        chk("reset rd_busy zero", 64'(rd_busy), 64'h0);
        step();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("r5 after reset", 64'(rd_data[31:0]), 64'h0);
        chk("r3 write discarded", 64'(rd_data[63:32]), 64'h0);
        chk("busy_vec after reset", 64'(busy_vec), 64'h0);
        step();

        // Basic dual write
        set_wr(0, 5'd3, 32'h12345678);
        set_wr(1, 5'd7, 32'hCAFEF00D);
        step();
        idle();
        set_rd(5'd3, 5'd7);
        @(negedge clk);
        chk("basic dual read", 64'(rd_data), 64'hCAFEF00D_12345678);
        step();

        // Zero register
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        issue(5'd0);
        step();
        idle();
        set_rd(5'd0, 5'd0);
        @(negedge clk);
        chk("r0 data", 64'(rd_data), 64'h0);
        chk("r0 busy_vec", 64'(busy_vec[0]), 64'h0);
        step();

        // Write conflict: port 1 wins
        set_wr(0, 5'd9, 32'h1);
        set_wr(1, 5'd9, 32'h2);
        step();
        idle();
        set_rd(5'd9, 5'd3);
        @(negedge clk);
        chk("conflict r9", 64'(rd_data[31:0]), 64'h2);
        step();

        // Scoreboard
        issue(5'd4);
        step();
        idle();
        set_rd(5'd4, 5'd9);
        @(negedge clk);
        chk("issue r4 busy", 64'(busy_vec[4]), 64'h1);
        chk("issue r4 rd_busy", 64'(rd_busy[0]), 64'h1);
        set_wr(1, 5'd4, 32'h77);
        step();
        idle();
        @(negedge clk);
        chk("writeback r4 busy", 64'(busy_vec[4]), 64'h0);
        issue(5'd4);
        set_wr(0, 5'd4, 32'hAA);
        step();
        idle();
        @(negedge clk);
        chk("issue+wb r4 busy", 64'(busy_vec[4]), 64'h1);
        chk("issue+wb r4 data", 64'(rd_data[31:0]), 64'hAA);
        step();

        // Bypass behaviour
        set_wr(0, 5'd6, 32'h11);
        step();
        idle();
        set_rd(5'd6, 5'd6);
        set_wr(1, 5'd6, 32'h55);
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("same-cycle r6", 64'(rd_data[31:0]), 64'h55);
`else
        chk("same-cycle r6", 64'(rd_data[31:0]), 64'h11);
`endif
        step();
        idle();
        @(negedge clk);
        chk("next-cycle r6", 64'(rd_data[31:0]), 64'h55);
        issue(5'd6);
        step();
        set_wr(0, 5'd6, 32'h66);
        issue(5'd6);
        step();
        set_wr(1, 5'd6, 32'h67);
        step();
        idle();

        // Deterministic mixed traffic, checked by the model each cycle
        for (int i = 0; i < 60; i++) begin
            set_rd(AW'((i * 5 + 1) % NREGS), AW'((i * 11 + 2) % NREGS));
            if (i % 3 != 0) set_wr(0, AW'((i * 7) % NREGS), 32'(i * 32'h01010101 + 3));
            if (i % 4 != 1) set_wr(1, AW'((i * 13 + 1) % NREGS), 32'(32'hF0000000 ^ (i * 97)));
            if (i % 2 == 0) issue(AW'((i * 3 + 1) % NREGS));
            step();
            idle();
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
- Parametrised register file: integer register file generalised in data width, register count, and number of read and write ports.
- Adds a per-register scoreboard of busy bits for the pipelined core.
- Sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥2).
- AW, $clog2(NREGS), register address width (derived; do not override).
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k's register has a pending write.
- wr_en  in  NWR  write enables, one per write port.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  AW  destination register being issued.
- busy_vec  out  NREGS  full scoreboard; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset, sampled at a rising edge of clk:
  - All NREGS registers are cleared to 0.
  - All busy bits are cleared.
  - Writes and issues in that cycle are discarded.
- Reads during reset: while reset is high, rd_data = 0 and rd_busy = 0 for every port.
- Reads:
  - Combinational; zero latency from rd_addr.
  - rd_data[k] = regs[rd_addr[k]].
  - rd_busy[k] = busy[rd_addr[k]].
  - Address 0 always returns data 0 and busy 0.
- Writes:
  - On the rising edge, for each j with wr_en[j] = 1 and wr_addr[j] != 0: regs[wr_addr[j]] <= wr_data[j].
  - Writes to address 0 are ignored.
- Write-write conflict: if both ports write the same address in one cycle, the higher-indexed port (port NWR-1) wins.
- Scoreboard update per edge, excluding register 0, with priority (highest first):
  1. If iss_en and iss_addr == r: busy[r] <= 1. A new producer overrides a same-cycle writeback of an older producer.
  2. Else if any wr_en[j] with wr_addr[j] == r: busy[r] <= 0.
  3. Else hold.
- Data write and issue together: a write to a register being issued in the same cycle still updates the data, but busy stays 1.
- Writes to non-busy registers: allowed; data updates and busy stays 0.
- Issue to address 0: ignored.
- busy_vec: direct register output; bit 0 is tied to 0.
- Read/write same cycle: behaviour depends on RF_BYPASS_EN (see Optional Feature).
- No internal FSM. State is the register array plus NREGS-1 busy flops.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined (write-through bypass): if read port k's address matches an enabled, non-zero write port in the same cycle:
  - rd_data[k] returns that port's wr_data; the highest-indexed matching port wins.
  - rd_busy[k] returns 0, unless iss_en targets the same address in that cycle.
- Not defined: reads return the pre-edge register contents and busy state. The new value is visible the cycle after the write.

Decomposition:
- Shared package rf_pkg holds:
  - Default constants XLEN_D = 32, NREGS_D = 32.
  - A zero-register address constant REG_ZERO = 0.
  - Helper function functions slice_addr and slice_data for packed-port indexing.
- One natural sub-module, rf_scoreboard: the busy-bit array with issue/clear priority.
- Data array and read muxing stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert reset one cycle → r5 reads 0, busy_vec = 0. With reset held, rd_data = 0 for all ports.
- Basic write/read: port0 writes r3 = 0x12345678 and port1 writes r7 = 0xCAFEF00D in one cycle → next cycle rd_addr = {7,3} returns {0xCAFEF00D, 0x12345678}.
- Zero register: write 0xFFFFFFFF to r0 and issue r0 → r0 reads 0 and busy_vec[0] = 0.
- Write conflict: both ports write r9, with 0x1 on port0 and 0x2 on port1 → r9 reads 0x2.
- Scoreboard: issue r4 → busy[4] = 1 next cycle. Writeback r4 alone → busy[4] = 0. Issue and writeback r4 in the same cycle with data 0xAA → busy[4] stays 1 and r4 reads 0xAA.
- Bypass: read r6 while writing 0x55 to r6 in the same cycle:
  - RF_BYPASS_EN defined → rd_data = 0x55 in that cycle.
  - Not defined → old value in that cycle, 0x55 the next cycle.
